// File: rtl/milano_pkg.sv
// milano_pkg: types and constants shared by the milano fetch stage and the
// decode stage that consumes the IF/ID boundary.
//   NOP_INSTR          - instruction substituted on fetch fault / empty slot
//   DEFAULT_BOOT_ADDR  - default reset PC
//   fetch_state_e      - fetch FSM states
//   if_id_t            - payload carried across the IF/ID boundary
package milano_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } if_id_t;

  // Value held in the boundary register when nothing valid is present.
  localparam if_id_t IF_ID_EMPTY = '{instr: NOP_INSTR, pc: 32'h0, fault: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: valid/ready output register of the fetch stage.
//   clk, rst   - clock, synchronous active-high reset
//   load_i     - capture data_i and present it as valid
//   flush_i    - drop any held entry (wins over load_i)
//   ready_i    - downstream accepts the held entry this cycle
//   data_i     - payload to capture
//   valid_o    - held entry is valid
//   data_o     - held payload (registered, stable while valid_o & ~ready_i)
module if_id_reg
  import milano_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   flush_i,
  input  logic   ready_i,
  input  if_id_t data_i,
  output logic   valid_o,
  output if_id_t data_o
);

  logic   valid_q;
  if_id_t data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= IF_ID_EMPTY;
    end else if (flush_i) begin
      // Payload is left as-is; only the valid bit matters once flushed.
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the milano core. Owns the PC, drives the
// word-addressed instruction ROM and registers instruction + PC into the
// IF/ID boundary with a valid/ready handshake.
//   clk, rst         - clock, synchronous active-high reset
//   fetch_en_i       - global fetch enable
//   rom_addr_o       - ROM byte address (always pc_q)
//   rom_en_o         - ROM read enable (asserted on a fetch)
//   rom_instr_i      - combinational ROM data for rom_addr_o
//   redirect_i       - redirect request from execute
//   redirect_pc_i    - redirect target byte address (bits [1:0] ignored)
//   id_ready_i       - decode accepts this cycle
//   id_valid_o       - id_* outputs valid
//   id_instr_o       - fetched instruction (NOP_INSTR on fault)
//   id_pc_o          - PC of id_instr_o
//   id_fault_o       - fetch was beyond the ROM
module instr_fetch
  import milano_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR,
  parameter int unsigned ROM_WORDS = 2048,
  parameter logic [31:0] NOP       = NOP_INSTR
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_en_o,
  input  logic [31:0] rom_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_fault_o
);

  localparam logic [31:0] ROM_WORDS_L = 32'(ROM_WORDS);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         out_free;
  logic         fire;
  logic         in_range;
  if_id_t       fetch_d;
  if_id_t       held;

  // Slot can take a new entry if empty or being drained this cycle.
  assign out_free = ~id_valid_o | id_ready_i;
  // rst gating keeps the ROM idle during reset even if state_q is still RUN.
  assign fire     = ~rst & (state_q == RUN) & fetch_en_i & out_free & ~redirect_i;
  assign in_range = {2'b00, pc_q[31:2]} < ROM_WORDS_L;

  assign rom_en_o   = fire;
  assign rom_addr_o = pc_q;

  always_comb begin
    fetch_d.instr = in_range ? rom_instr_i : NOP;
    fetch_d.pc    = pc_q;
    fetch_d.fault = ~in_range;
  end

  // FSM and PC. pc_q + 4 wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en_i)  state_q <= RUN;
        RUN:     if (!fetch_en_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (redirect_i)
        pc_q <= redirect_pc_i & ~32'd3;
      else if (fire)
        pc_q <= pc_q + 32'd4;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (fire),
    .flush_i (redirect_i),
    .ready_i (id_ready_i),
    .data_i  (fetch_d),
    .valid_o (id_valid_o),
    .data_o  (held)
  );

  assign id_instr_o = held.instr;
  assign id_pc_o    = held.pc;
  assign id_fault_o = held.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard: the stimulus pushes each
// instruction decode is expected to accept; a monitor pops on every accepted
// handshake. ROM model: word index i holds {16'hA5A5, i[15:0]}.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en_i = 1'b0;
  logic [31:0] rom_addr_o;
  logic        rom_en_o;
  logic [31:0] rom_instr_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        id_ready_i = 1'b1;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_fault_o;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign rom_instr_i = {16'hA5A5, rom_addr_o[17:2]};

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en_i    (fetch_en_i),
    .rom_addr_o    (rom_addr_o),
    .rom_en_o      (rom_en_o),
    .rom_instr_i   (rom_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_ready_i    (id_ready_i),
    .id_valid_o    (id_valid_o),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_fault_o    (id_fault_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc = pc; e.instr = instr; e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && id_valid_o && id_ready_i) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL unexpected_accept: pc %h instr %h, scoreboard empty", id_pc_o, id_instr_o);
        end else begin
          e = sb.pop_front();
          $display("[TB] accept pc=%h instr=%h fault=%0d", id_pc_o, id_instr_o, id_fault_o);
          chk("acc_pc", id_pc_o, e.pc);
          chk("acc_instr", id_instr_o, e.instr);
          chk("acc_fault", {31'b0, id_fault_o}, {31'b0, e.fault});
        end
      end
    end
  end

  initial begin
    // Reset state; fetch_en high during reset must not enable the ROM.
    fetch_en_i = 1'b1;
    step(); step();
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_instr", id_instr_o, 32'h0000_0013);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_fault", {31'b0, id_fault_o}, 32'd0);
    chk("rst_rom_addr", rom_addr_o, 32'h0);
    chk("rst_rom_en", {31'b0, rom_en_o}, 32'd0);

    // Streaming fetch of words 0..3.
    push(32'h0, 32'hA5A5_0000, 1'b0);
    push(32'h4, 32'hA5A5_0001, 1'b0);
    push(32'h8, 32'hA5A5_0002, 1'b0);
    push(32'hC, 32'hA5A5_0003, 1'b0);
    rst = 1'b0;
    step();                       // IDLE -> RUN
    chk("run_no_valid_yet", {31'b0, id_valid_o}, 32'd0);
    chk("run_rom_en", {31'b0, rom_en_o}, 32'd1);
    step();
    chk("s0_pc", id_pc_o, 32'h0);
    step();
    chk("s1_valid", {31'b0, id_valid_o}, 32'd1);
    chk("s1_pc", id_pc_o, 32'h4);
    step();
    chk("s2_pc", id_pc_o, 32'h8);

    // Stall 3 cycles holding pc=8.
    id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rom_en", {31'b0, rom_en_o}, 32'd0);
      chk("stall_rom_addr", rom_addr_o, 32'hC);
      step();
      chk("stall_pc", id_pc_o, 32'h8);
      chk("stall_instr", id_instr_o, 32'hA5A5_0002);
      chk("stall_valid", {31'b0, id_valid_o}, 32'd1);
    end
    id_ready_i = 1'b1;
    step();
    chk("release_pc", id_pc_o, 32'hC);

    // Stall on pc=C, then redirect to 0x103: C is dropped.
    id_ready_i = 1'b0;
    step();
    chk("stall2_pc", id_pc_o, 32'hC);
    sb.delete(sb.size() - 1);     // pc=C will be flushed, never accepted
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    #1;
    chk("redir_rom_en", {31'b0, rom_en_o}, 32'd0);
    step();
    redirect_i = 1'b0;
    chk("flush_valid", {31'b0, id_valid_o}, 32'd0);
    chk("redir_pc_aligned", rom_addr_o, 32'h100);
    id_ready_i = 1'b1;
    push(32'h100, 32'hA5A5_0040, 1'b0);
    step();
    chk("tgt_pc", id_pc_o, 32'h100);

    // Redirect to first out-of-range word.
    push(32'h2000, 32'h0000_0013, 1'b1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_2000;
    step();
    redirect_i = 1'b0;
    step();
    chk("fault_flag", {31'b0, id_fault_o}, 32'd1);
    chk("fault_instr", id_instr_o, 32'h0000_0013);
    chk("fault_pc_adv", rom_addr_o, 32'h2004);

    // Redirect to the top word: pc wraps to 0 after one fetch.
    push(32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
    push(32'h0, 32'hA5A5_0000, 1'b0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    step();
    chk("wrap_pc_out", id_pc_o, 32'hFFFF_FFFC);
    chk("wrap_rom_addr", rom_addr_o, 32'h0);
    step();
    chk("after_wrap_pc", id_pc_o, 32'h0);

    // Reset mid-stream discards the in-flight word (pc=0 not accepted).
    void'(sb.pop_back());
    rst = 1'b1;
    #1;
    chk("rst_rom_en_mid", {31'b0, rom_en_o}, 32'd0);
    step();
    chk("mid_rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("mid_rst_pc", rom_addr_o, 32'h0);
    chk("mid_rst_instr", id_instr_o, 32'h0000_0013);

    // fetch_en 1,0,1 with decode stalled.
    push(32'h0, 32'hA5A5_0000, 1'b0);
    push(32'h4, 32'hA5A5_0001, 1'b0);
    rst = 1'b0;
    step();
    step();
    chk("fe_first_pc", id_pc_o, 32'h0);
    id_ready_i = 1'b0;
    fetch_en_i = 1'b0;
    step();
    chk("fe_off_hold_valid", {31'b0, id_valid_o}, 32'd1);
    chk("fe_off_hold_pc", id_pc_o, 32'h0);
    chk("fe_off_rom_en", {31'b0, rom_en_o}, 32'd0);
    fetch_en_i = 1'b1;
    step();
    chk("fe_on_stall_rom_en", {31'b0, rom_en_o}, 32'd0);
    chk("fe_on_hold_pc", id_pc_o, 32'h0);
    chk("fe_on_rom_addr", rom_addr_o, 32'h4);
    id_ready_i = 1'b1;
    step();
    chk("fe_next_pc", id_pc_o, 32'h4);
    fetch_en_i = 1'b0;
    step();
    chk("fe_drain_valid", {31'b0, id_valid_o}, 32'd0);
    chk("fe_no_fetch", rom_addr_o, 32'h8);
    step(); step();

    tests++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
